nv_ram_rd_stream_160x514: RTL and testbench

Read-side streaming controller for the 160-entry x 514-bit two-port RAM (registered read address, output register enabled by `ore`). It accepts a burst request (start address, beat count), drives the RAM read port with correct `re`/`ore` sequencing, and absorbs the 2-cycle RAM read latency in a small landing buffer. Data leaves on a valid/ready stream. The block sits between a consumer datapath and the RAM, opposite the producer that drives `wa`/`we`/`di`.

---
 rtl/nv_ram_rd_stream_pkg.sv | 11 +
 rtl/nv_ram_rd_stream_fifo.sv | 40 ++++
 rtl/nv_ram_rd_stream_160x514.sv | 108 ++++++++++
 tb/tb_nv_ram_rd_stream_160x514.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/nv_ram_rd_stream_pkg.sv
// nv_ram_rd_stream_pkg: shared defaults, FSM state type and address-wrap helper
package nv_ram_rd_stream_pkg;
  localparam int DEF_DEPTH     = 160;
  localparam int DEF_AW        = 8;
  localparam int DEF_DW        = 514;
  localparam int DEF_BUF_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  function automatic logic [DEF_AW-1:0] addr_inc(input logic [DEF_AW-1:0] a, input int depth);
    return (32'(a) == depth - 1) ? '0 : a + 1'b1;
  endfunction
endpackage

// File: rtl/nv_ram_rd_stream_fifo.sv
// nv_ram_rd_stream_fifo: small register FIFO landing RAM read data with simultaneous push/pop
module nv_ram_rd_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rp];
  // pointers and occupancy; reset empties the buffer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= ptr_inc(r_wp);
      if (i_pop) r_rp <= ptr_inc(r_rp);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end
  // storage needs no reset; occupancy gates what is visible
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/nv_ram_rd_stream_160x514.sv
// nv_ram_rd_stream_160x514: burst read streamer for the 160x514 RAM; optional err port via NV_RAM_RD_STREAM_ERR_CHK_EN
module nv_ram_rd_stream_160x514
  import nv_ram_rd_stream_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
`ifdef NV_RAM_RD_STREAM_ERR_CHK_EN
  ,
  output logic          err
`endif
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr, r_rem, r_ra, w_addr_in, w_len_in;
  logic [CW-1:0] r_credits;
  logic          r_s1, r_s1_last, r_s2, r_s2_last;
  logic          w_accept, w_issue, w_pop, w_empty;
  logic [DW:0]   w_head;
  assign req_ready = (r_state == IDLE);
  assign busy      = !req_ready;
  assign w_accept  = req_valid & req_ready;
  assign w_issue   = (r_state == ISSUE) && (r_credits != '0);
  assign w_pop     = out_valid & out_ready;
  assign ram_re    = w_issue;
  assign ram_ra    = w_issue ? r_addr : r_ra;
  assign ram_ore   = r_s1;
  assign out_valid = !w_empty;
  assign out_data  = w_head[DW-1:0];
  assign out_last  = !w_empty & w_head[DW];
`ifdef NV_RAM_RD_STREAM_ERR_CHK_EN
  assign w_addr_in = (32'(req_addr) >= DEPTH) ? AW'(32'(req_addr) % DEPTH) : req_addr;
  assign w_len_in  = (32'(req_len) >= DEPTH) ? AW'(DEPTH - 1) : req_len;
  // sticky flag for out-of-range requests, cleared only by reset
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) err <= 1'b0;
    else if (w_accept && (32'(req_addr) >= DEPTH || 32'(req_len) >= DEPTH)) err <= 1'b1;
  end
`else
  assign w_addr_in = req_addr;
  assign w_len_in  = req_len;
`endif
  // next state: accept -> issue, last issue -> drain, last pop -> idle
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE && w_accept) ? ISSUE :
                  (w_issue && r_rem == '0) ? DRAIN :
                  (r_state == DRAIN && w_pop && out_last) ? IDLE : r_state;
  end
  // burst bookkeeping, credits and the two-stage read-latency tags
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_ra      <= '0;
      r_credits <= '0;
      r_s1      <= 1'b0;
      r_s1_last <= 1'b0;
      r_s2      <= 1'b0;
      r_s2_last <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s1      <= w_issue;
      r_s1_last <= w_issue && r_rem == '0;
      r_s2      <= r_s1;
      r_s2_last <= r_s1_last;
      if (w_accept) begin
        r_addr    <= w_addr_in;
        r_rem     <= w_len_in;
        r_credits <= CW'(BUF_DEPTH);
      end else begin
        r_credits <= r_credits - CW'(w_issue) + CW'(w_pop);
        if (w_issue) begin
          r_addr <= addr_inc(r_addr, DEPTH);
          r_rem  <= r_rem - 1'b1;
          r_ra   <= r_addr;
        end
      end
    end
  end
  nv_ram_rd_stream_fifo #(.DEPTH(BUF_DEPTH), .W(DW + 1)) u_fifo (
    .i_clk   (nvdla_core_clk),
    .i_rst_n (nvdla_core_rstn),
    .i_push  (r_s2),
    .i_data  ({r_s2_last, ram_dout}),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_head  (w_head)
  );
endmodule

// File: tb/tb_nv_ram_rd_stream_160x514.sv
// tb_nv_ram_rd_stream_160x514: directed bench with a behavioural two-port RAM preloaded M[i]=i
module tb_nv_ram_rd_stream_160x514;
  localparam int DEPTH = 160;
  localparam int AW = 8;
  localparam int DW = 514;
  localparam int BUF_DEPTH = 4;
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_len = '0;
  logic [AW-1:0] ram_ra;
  logic          ram_re, ram_ore;
  logic [DW-1:0] ram_dout;
  logic          out_valid, out_last, busy;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q;
  int vectors = 0;
  int miscompares = 0;
`ifdef NV_RAM_RD_STREAM_ERR_CHK_EN
  logic err;
`endif
  always #5 clk = ~clk;
  nv_ram_rd_stream_160x514 dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_len         (req_len),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_ore         (ram_ore),
    .ram_dout        (ram_dout),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy)
`ifdef NV_RAM_RD_STREAM_ERR_CHK_EN
    ,
    .err             (err)
`endif
  );
  always @(posedge clk) begin
    if (ram_re) ra_q <= ram_ra;
    if (ram_ore) ram_dout <= mem[ra_q];
  end
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic burst(input int addr, input int len, input int mode, input int start);
    int k, n, first, re_cnt;
    logic done;
    @(negedge clk);
    chk("req_ready_idle", DW'(req_ready), DW'(1));
    req_valid = 1'b1;
    req_addr = AW'(addr);
    req_len = AW'(len);
    out_ready = (mode == 0);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1; n = 0; first = -1; re_cnt = 0; done = 1'b0;
    while (!done && k < 5000) begin
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (k > 10);
      if (ram_re) re_cnt++;
      if (mode == 2 && k == 10) chk("stall_reads", DW'(re_cnt), DW'(BUF_DEPTH));
      if (out_valid && first < 0) first = k;
      if (out_valid && out_ready) begin
        chk("beat_data", out_data, DW'((start + n) % DEPTH));
        chk("beat_last", DW'(out_last), DW'(n == len));
        if (mode == 0) chk("beat_cycle", DW'(k), DW'(first + n));
        if (n == len) begin
          chk("busy_at_last", DW'(busy), DW'(1));
          done = 1'b1;
        end
        n++;
      end
      @(negedge clk);
      k++;
    end
    chk("burst_done", DW'(done), DW'(1));
    chk("beat_count", DW'(n), DW'(len + 1));
    if (mode == 0) chk("first_latency", DW'(first), DW'(4));
    chk("busy_after", DW'(busy), DW'(0));
    chk("req_ready_after", DW'(req_ready), DW'(1));
  endtask
  initial begin
    logic seen;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    #1;
    chk("rst_re", DW'(ram_re), DW'(0));
    chk("rst_ore", DW'(ram_ore), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_req_ready", DW'(req_ready), DW'(1));
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_last", DW'(out_last), DW'(0));
    chk("rst_ra", DW'(ram_ra), DW'(0));
`ifdef NV_RAM_RD_STREAM_ERR_CHK_EN
    chk("rst_err", DW'(err), DW'(0));
`endif
    burst(5, 3, 0, 5);
    burst(158, 3, 0, 158);
    burst(0, 9, 2, 0);
    burst(0, 159, 1, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = AW'(20);
    req_len = AW'(20);
    out_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", DW'(out_valid), DW'(1));
    chk("pre_rst_ore", DW'(ram_ore), DW'(1));
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(out_valid), DW'(0));
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_re", DW'(ram_re), DW'(0));
    chk("mid_rst_ore", DW'(ram_ore), DW'(0));
    chk("mid_rst_last", DW'(out_last), DW'(0));
    chk("mid_rst_ra", DW'(ram_ra), DW'(0));
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_beat_after_rst", DW'(seen), DW'(0));
    burst(30, 5, 0, 30);
`ifdef NV_RAM_RD_STREAM_ERR_CHK_EN
    burst(170, 3, 0, 10);
    chk("err_sticky", DW'(err), DW'(1));
    burst(2, 1, 0, 2);
    chk("err_still", DW'(err), DW'(1));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
